// File: rtl/i2s_tx_ctrl_if.sv
// Signal bundle between the I2S TX sequencer and its config/FIFO/channel neighbours.
// frame_cnt_o is only present when I2S_TX_CTRL_FRAME_CNT_EN is defined.
interface i2s_tx_ctrl_if
`ifdef I2S_TX_CTRL_FRAME_CNT_EN
    #(parameter int FRAME_CNT_W = 16)
`endif
    ;
    logic       cfg_en_i;
    logic [4:0] cfg_wlen_i;
    logic [2:0] cfg_wnum_i;
    logic       fifo_data_valid_i;
    logic       fifo_data_ready_i;
    logic       ch_en_o;
    logic       i2s_ws_o;
    logic       busy_o;
    logic       err_underrun_o;
`ifdef I2S_TX_CTRL_FRAME_CNT_EN
    logic [FRAME_CNT_W-1:0] frame_cnt_o;
`endif

    modport master (
        input  cfg_en_i, cfg_wlen_i, cfg_wnum_i, fifo_data_valid_i, fifo_data_ready_i,
`ifdef I2S_TX_CTRL_FRAME_CNT_EN
        output frame_cnt_o,
`endif
        output ch_en_o, i2s_ws_o, busy_o, err_underrun_o
    );

    modport slave (
        output cfg_en_i, cfg_wlen_i, cfg_wnum_i, fifo_data_valid_i, fifo_data_ready_i,
`ifdef I2S_TX_CTRL_FRAME_CNT_EN
        input  frame_cnt_o,
`endif
        input  ch_en_o, i2s_ws_o, busy_o, err_underrun_o
    );
endinterface

// File: rtl/i2s_tx_ctrl.sv
// Master-mode WS/enable sequencer for one I2S TX channel (sck domain).
// Optional completed-frame counter enabled by macro I2S_TX_CTRL_FRAME_CNT_EN.
module i2s_tx_ctrl #(
    parameter int PRIME_WORDS = 2
`ifdef I2S_TX_CTRL_FRAME_CNT_EN
    , parameter int FRAME_CNT_W = 16
`endif
) (
    input logic          sck_i,
    input logic          rstn_i,
    i2s_tx_ctrl_if.master bus
);

    typedef enum logic [1:0] {IDLE, PRIME, RUN, DRAIN} state_t;

    localparam logic [1:0] PRIME_TGT = 2'(PRIME_WORDS);

    state_t     state, state_next;
    logic       ws, ws_next;
    logic [4:0] bit_cnt, bit_next, wlen;
    logic [2:0] word_cnt, word_next, wnum;
    logic [1:0] prime_cnt, prime_next;
    logic       err, err_next;
    logic       latch_cfg;
    logic       right_done;
    logic       term;
    logic       handshake;

    assign term      = (bit_cnt == wlen) && (word_cnt == wnum);
    assign handshake = bus.fifo_data_valid_i & bus.fifo_data_ready_i;

    always_ff @(posedge sck_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state     <= IDLE;
            ws        <= 1'b0;
            bit_cnt   <= '0;
            word_cnt  <= '0;
            prime_cnt <= '0;
            err       <= 1'b0;
            wlen      <= '0;
            wnum      <= '0;
        end else begin
            state     <= state_next;
            ws        <= ws_next;
            bit_cnt   <= bit_next;
            word_cnt  <= word_next;
            prime_cnt <= prime_next;
            err       <= err_next;
            if (latch_cfg) begin
                wlen <= bus.cfg_wlen_i;
                wnum <= bus.cfg_wnum_i;
            end
        end
    end

    always_comb begin
        state_next = state;
        ws_next    = ws;
        bit_next   = bit_cnt;
        word_next  = word_cnt;
        prime_next = prime_cnt;
        err_next   = 1'b0;
        latch_cfg  = 1'b0;
        right_done = 1'b0;
        case (state)
            IDLE: begin
                ws_next    = 1'b0;
                bit_next   = '0;
                word_next  = '0;
                prime_next = '0;
                if (bus.cfg_en_i) begin
                    state_next = PRIME;
                    ws_next    = 1'b1;
                    latch_cfg  = 1'b1;
                end
            end
            PRIME: begin
                // A stop request wins over a handshake that would finish priming.
                ws_next = 1'b1;
                if (!bus.cfg_en_i) begin
                    state_next = IDLE;
                    ws_next    = 1'b0;
                    prime_next = '0;
                end else if (handshake) begin
                    if (prime_cnt + 2'd1 == PRIME_TGT) begin
                        state_next = RUN;
                        ws_next    = 1'b0;
                        prime_next = '0;
                    end else begin
                        prime_next = prime_cnt + 2'd1;
                    end
                end
            end
            RUN, DRAIN: begin
                err_next = bus.fifo_data_ready_i & ~bus.fifo_data_valid_i;
                if (term) begin
                    bit_next  = '0;
                    word_next = '0;
                    ws_next   = ~ws;
                end else if (bit_cnt == wlen) begin
                    bit_next  = '0;
                    word_next = word_cnt + 3'd1;
                end else begin
                    bit_next = bit_cnt + 5'd1;
                end
                right_done = term & ws;
                // Stopping is only allowed once a full right half has gone out.
                if (bus.cfg_en_i) begin
                    state_next = RUN;
                end else if (right_done) begin
                    state_next = IDLE;
                    ws_next    = 1'b0;
                end else begin
                    state_next = DRAIN;
                end
            end
            default: begin
                state_next = IDLE;
                ws_next    = 1'b0;
            end
        endcase
    end

`ifdef I2S_TX_CTRL_FRAME_CNT_EN
    logic [FRAME_CNT_W-1:0] frame_cnt;

    always_ff @(posedge sck_i or negedge rstn_i) begin
        if (!rstn_i) begin
            frame_cnt <= '0;
        end else if (latch_cfg) begin
            frame_cnt <= '0;
        end else if (right_done && (frame_cnt != {FRAME_CNT_W{1'b1}})) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

    assign bus.frame_cnt_o = frame_cnt;
`endif

    assign bus.ch_en_o        = (state != IDLE);
    assign bus.busy_o         = (state != IDLE);
    assign bus.i2s_ws_o       = ws;
    assign bus.err_underrun_o = err;

endmodule

// File: tb/tb_i2s_tx_ctrl.sv
// Self-checking bench for i2s_tx_ctrl: hand-computed vector table, directed
// corner sequences and a randomized run against a frame-position reference model.
module tb_i2s_tx_ctrl;

    localparam int PW     = 2;
    localparam int FC_MAX = 65535;

    logic sck;
    logic rstn;

    i2s_tx_ctrl_if bus();

    i2s_tx_ctrl #(.PRIME_WORDS(PW)) dut (
        .sck_i  (sck),
        .rstn_i (rstn),
        .bus    (bus)
    );

    initial sck = 1'b0;
    always #5 sck = ~sck;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: mode 0=idle 1=prime 2=run 3=drain, position within the stereo frame.
    int          m_mode, m_pos, m_primed, m_wl, m_wn;
    logic        m_err;
    int unsigned m_fc;

    typedef struct {
        logic       en;
        logic       v;
        logic       r;
        logic [3:0] exp;
    } vec_t;

    function automatic int half_len();
        return (m_wl + 1) * (m_wn + 1);
    endfunction

    function automatic logic [3:0] model_out();
        logic exp_ws;
        exp_ws = 1'b0;
        if (m_mode == 1) exp_ws = 1'b1;
        else if (m_mode >= 2) exp_ws = (m_pos >= half_len());
        return {m_mode != 0, exp_ws, m_mode != 0, m_err};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_primed = 0; m_wl = 0; m_wn = 0;
        m_err = 1'b0; m_fc = 0;
    endtask

    task automatic model_next();
        int  len;
        bit  en, v, r, half_end, right;
        en  = bus.cfg_en_i;
        v   = bus.fifo_data_valid_i;
        r   = bus.fifo_data_ready_i;
        len = half_len();
        case (m_mode)
            0: begin
                m_err = 1'b0;
                if (en) begin
                    m_mode = 1; m_primed = 0; m_fc = 0; m_pos = 0;
                    m_wl = int'(bus.cfg_wlen_i); m_wn = int'(bus.cfg_wnum_i);
                end
            end
            1: begin
                m_err = 1'b0;
                if (!en) m_mode = 0;
                else if (v && r) begin
                    m_primed++;
                    if (m_primed == PW) begin m_mode = 2; m_pos = 0; end
                end
            end
            default: begin
                half_end = ((m_pos % len) == len - 1);
                right    = (m_pos >= len);
                m_err    = r && !v;
                if (half_end && right && m_fc < FC_MAX) m_fc++;
                if (!en && half_end && right) begin
                    m_mode = 0; m_pos = 0;
                end else begin
                    m_mode = en ? 2 : 3;
                    m_pos  = (m_pos + 1) % (2 * len);
                end
            end
        endcase
    endtask

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [3:0] dut_out();
        return {bus.ch_en_o, bus.i2s_ws_o, bus.busy_o, bus.err_underrun_o};
    endfunction

    task automatic check_output();
        compare("outputs", 32'(dut_out()), 32'(model_out()));
`ifdef I2S_TX_CTRL_FRAME_CNT_EN
        compare("frame_cnt", 32'(bus.frame_cnt_o), m_fc);
`endif
    endtask

    task automatic apply_stimulus(input logic en, input logic [4:0] wl, input logic [2:0] wn,
                                  input logic v, input logic r);
        bus.cfg_en_i          = en;
        bus.cfg_wlen_i        = wl;
        bus.cfg_wnum_i        = wn;
        bus.fifo_data_valid_i = v;
        bus.fifo_data_ready_i = r;
    endtask

    task automatic step();
        model_next();
        @(posedge sck);
        @(negedge sck);
        check_output();
    endtask

    // Asserts reset between clock edges and checks the outputs clear without an edge.
    task automatic do_reset();
        #2 rstn = 1'b0;
        #1 compare("async_reset_outputs", 32'(dut_out()), 32'h0);
`ifdef I2S_TX_CTRL_FRAME_CNT_EN
        compare("async_reset_frame_cnt", 32'(bus.frame_cnt_o), 32'h0);
`endif
        apply_stimulus(1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
        model_reset();
        @(negedge sck);
        rstn = 1'b1;
        check_output();
    endtask

    task automatic prime_start(input logic [4:0] wl, input logic [2:0] wn);
        apply_stimulus(1'b1, wl, wn, 1'b1, 1'b1);
        for (int i = 0; i < 1 + PW; i++) step();
    endtask

    vec_t table_v[10];

    initial begin
        int   n;
        logic en;

        table_v[0] = '{1'b1, 1'b0, 1'b0, 4'b1110};
        table_v[1] = '{1'b1, 1'b1, 1'b1, 4'b1110};
        table_v[2] = '{1'b1, 1'b1, 1'b1, 4'b1010};
        table_v[3] = '{1'b1, 1'b1, 1'b1, 4'b1010};
        table_v[4] = '{1'b1, 1'b0, 1'b1, 4'b1111};
        table_v[5] = '{1'b1, 1'b1, 1'b0, 4'b1110};
        table_v[6] = '{1'b0, 1'b1, 1'b0, 4'b0000};
        table_v[7] = '{1'b1, 1'b0, 1'b1, 4'b1110};
        table_v[8] = '{1'b1, 1'b0, 1'b1, 4'b1110};
        table_v[9] = '{1'b0, 1'b0, 1'b0, 4'b0000};

        rstn = 1'b0;
        apply_stimulus(1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
        model_reset();
        @(negedge sck);
        @(negedge sck);
        compare("reset_outputs", 32'(dut_out()), 32'h0);
        rstn = 1'b1;
        @(negedge sck);
        check_output();

        // Table: L=2, prime, run, underrun, stop at right-half end, abort in prime.
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(table_v[i].en, 5'd1, 3'd0, table_v[i].v, table_v[i].r);
            step();
            compare($sformatf("table[%0d]", i), 32'(dut_out()), 32'(table_v[i].exp));
        end

        // Stereo 16-bit, then graceful stop dropped in the left half of frame two.
        prime_start(5'd15, 3'd0);
        for (int i = 0; i < 40; i++) step();
        bus.cfg_en_i = 1'b0;
        n = 0;
        for (int i = 0; i < 100 && bus.busy_o; i++) begin step(); n++; end
        compare("drain_length", 32'(n), 32'd24);
        compare("drain_idle_outputs", 32'(dut_out()), 32'h0);

        // Multi-word half-frame; wlen changes mid-run must not take effect.
        prime_start(5'd7, 3'd3);
        for (int i = 0; i < 20; i++) step();
        bus.cfg_wlen_i = 5'd31;
        for (int i = 0; i < 100; i++) step();
        bus.cfg_en_i = 1'b0;
        for (int i = 0; i < 300 && bus.busy_o; i++) step();
        compare("multiword_stopped", 32'(bus.busy_o), 32'h0);

        // Abort in PRIME with ready but no valid: no underrun, no ws edge.
        apply_stimulus(1'b1, 5'd3, 3'd0, 1'b0, 1'b1);
        step(); step(); step();
        bus.cfg_en_i = 1'b0;
        step();
        compare("abort_prime", 32'(dut_out()), 32'h0);

        // Three consecutive underrun cycles give three consecutive pulses.
        prime_start(5'd3, 3'd0);
        step(); step();
        bus.fifo_data_valid_i = 1'b0;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) bus.fifo_data_valid_i = 1'b1;
            step();
            n += int'(bus.err_underrun_o);
        end
        compare("underrun_pulses", 32'(n), 32'd3);

        // Async reset during DRAIN, then restart and count frames.
        bus.cfg_en_i = 1'b0;
        step(); step();
        do_reset();
        prime_start(5'd1, 3'd0);
        for (int i = 0; i < 12; i++) step();
`ifdef I2S_TX_CTRL_FRAME_CNT_EN
        compare("frame_cnt_after_3", 32'(bus.frame_cnt_o), 32'd3);
`endif
        bus.cfg_en_i = 1'b0;
        for (int i = 0; i < 20 && bus.busy_o; i++) step();

        // Randomized run with sticky enable and cfg churn.
        en = 1'b0;
        for (int ep = 0; ep < 30; ep++) begin
            for (int c = 0; c < 150; c++) begin
                if ($urandom_range(0, 19) == 0) en = ~en;
                if (c == 0) en = 1'b1;
                apply_stimulus(en, 5'($urandom_range(0, 7)), 3'($urandom_range(0, 3)),
                               1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)));
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
